// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundles the fetch-stage buses: instruction-memory request and
//               response, redirect input and the decode-side valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage: owns the PC, issues in-order memory reads, buffers
//               returned words and flushes stale responses on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input wire            clk,
    input wire            rst,
    instr_fetch_if.master bus
);
    localparam int c_CW  = $clog2(BUF_DEPTH + 1);
    localparam int c_CW1 = c_CW + 1;
    localparam int c_PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [c_CW:0]   c_DEPTH = c_CW1'(BUF_DEPTH);
    localparam logic [c_PW-1:0] c_LAST  = c_PW'(BUF_DEPTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + 1'b1;
    endfunction

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_stale_addr;
    logic                  r_req_pending;
    logic                  r_req_stale;
    logic [c_CW-1:0]       r_out;
    logic [c_CW-1:0]       r_drop;
    logic [c_CW-1:0]       r_fifo_cnt;
    logic [c_PW-1:0]       r_fifo_wr;
    logic [c_PW-1:0]       r_fifo_rd;
    logic [c_PW-1:0]       r_tag_wr;
    logic [c_PW-1:0]       r_tag_rd;
    logic [DATA_WIDTH-1:0] r_fifo_data [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] r_tag_addr  [BUF_DEPTH];

    logic                  w_pop;
    logic [c_CW:0]         w_load;
    logic                  w_credit_ok;
    logic                  w_req_valid;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_accept;
    logic                  w_drop_rsp;
    logic                  w_push;
    logic                  w_stale_next;
    logic [c_CW-1:0]       w_out_next;
    logic [c_CW-1:0]       w_drop_next;
    logic [1:0]            w_state_next;
    logic                  w_unused;

    always_comb begin
        w_pop       = (r_fifo_cnt != '0) & bus.instr_ready;
        // A slot freed by this cycle's pop may be reused at once, sustaining one word per cycle.
        w_load      = {1'b0, r_out} + {1'b0, r_fifo_cnt} - c_CW1'(w_pop);
        w_credit_ok = (w_load < c_DEPTH);
        w_req_valid = r_req_pending | ((r_state == c_ST_RUN) & w_credit_ok);
        w_req_addr  = r_req_stale ? r_stale_addr : r_pc;
        w_accept    = w_req_valid & bus.imem_req_ready;
        w_drop_rsp  = bus.imem_rsp_valid & (r_drop != '0);
        w_push      = bus.imem_rsp_valid & ~w_drop_rsp & ~bus.redirect_valid;
        w_out_next  = r_out + c_CW'(w_accept) - c_CW'(bus.imem_rsp_valid);
        // A request still waiting at redirect keeps its old address; its response is dropped later.
        w_stale_next = (r_req_stale | bus.redirect_valid) & w_req_valid & ~w_accept;

        if (bus.redirect_valid) begin
            w_drop_next = w_out_next;
        end else begin
            w_drop_next = r_drop - c_CW'(w_drop_rsp) + c_CW'(w_accept & r_req_stale);
        end

        w_state_next = r_state;
        if (bus.redirect_valid) begin
            w_state_next = ((w_drop_next != '0) | w_stale_next) ? c_ST_FLUSH : c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_IDLE:  w_state_next = c_ST_RUN;
                c_ST_RUN:   w_state_next = c_ST_RUN;
                c_ST_FLUSH: w_state_next = ((w_drop_next == '0) & ~w_stale_next) ? c_ST_RUN : c_ST_FLUSH;
                default:    w_state_next = c_ST_IDLE;
            endcase
        end
    end

    assign w_unused = ^bus.redirect_pc[1:0];

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = w_req_addr;
    assign bus.instr_valid    = (r_fifo_cnt != '0);
    assign bus.instruction    = (r_fifo_cnt != '0) ? r_fifo_data[r_fifo_rd] : '0;
    assign bus.instr_pc       = (r_fifo_cnt != '0) ? r_fifo_pc[r_fifo_rd]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_pc          <= RESET_PC;
            r_stale_addr  <= '0;
            r_req_pending <= 1'b0;
            r_req_stale   <= 1'b0;
            r_out         <= '0;
            r_drop        <= '0;
            r_fifo_cnt    <= '0;
            r_fifo_wr     <= '0;
            r_fifo_rd     <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_req_pending <= w_req_valid & ~w_accept;
            r_req_stale   <= w_stale_next;
            r_out         <= w_out_next;
            r_drop        <= w_drop_next;

            if (bus.redirect_valid & ~r_req_stale) begin
                r_stale_addr <= r_pc;
            end

            if (bus.redirect_valid) begin
                r_pc <= {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            end else if (w_accept & ~r_req_stale) begin
                r_pc <= r_pc + ADDR_WIDTH'(4);
            end

            if (w_accept) begin
                r_tag_wr <= f_ptr_inc(r_tag_wr);
            end
            if (bus.imem_rsp_valid) begin
                r_tag_rd <= f_ptr_inc(r_tag_rd);
            end

            if (bus.redirect_valid) begin
                r_fifo_cnt <= '0;
                r_fifo_wr  <= '0;
                r_fifo_rd  <= '0;
            end else begin
                r_fifo_cnt <= r_fifo_cnt + c_CW'(w_push) - c_CW'(w_pop);
                if (w_push) begin
                    r_fifo_wr <= f_ptr_inc(r_fifo_wr);
                end
                if (w_pop) begin
                    r_fifo_rd <= f_ptr_inc(r_fifo_rd);
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters and pointers.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_addr[r_tag_wr] <= w_req_addr;
        end
        if (w_push) begin
            r_fifo_data[r_fifo_wr] <= bus.imem_rsp_data;
            r_fifo_pc[r_fifo_wr]   <= r_tag_addr[r_tag_rd];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch with a fixed-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    instr_fetch #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0100),
        .BUF_DEPTH (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] issued[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];

    int          cyc = 0;
    int          lat = 1;
    bit          mem_ready = 1'b1;
    bit          dec_ready = 1'b1;
    bit          redir = 1'b0;
    logic [31:0] redir_pc = '0;
    int          checks = 0;
    int          failures = 0;

    // One clock cycle: drive this cycle's inputs, record handshakes, advance past the edge.
    task automatic tick();
        mreq_t m;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (mq.size() > 0) begin
            m = mq[0];
            if (m.due == cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = ~m.addr;
                mq.delete(0);
            end
        end
        bus.imem_req_ready = mem_ready;
        bus.instr_ready    = dec_ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir_pc;
        #1;
        if (!rst && bus.imem_req_valid === 1'b1 && mem_ready) begin
            m.addr = bus.imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            issued.push_back(bus.imem_req_addr);
        end
        if (!rst && bus.instr_valid === 1'b1 && dec_ready) begin
            got_pc.push_back(bus.instr_pc);
            got_ins.push_back(bus.instruction);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        lat = l;
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        redir = 1'b0;
        redir_pc = '0;
        tick();
        tick();
        mq.delete();
        issued.delete();
        got_pc.delete();
        got_ins.delete();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic test_reset();
        do_reset(1);
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
        checks++;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
        checks++;
        if (bus.instruction !== 32'h0) begin failures++; $display("FAIL reset_instruction: got %h want 0", bus.instruction); end
        checks++;
        if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_c1: got %b want 0", bus.instr_valid); end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_c2: got %b want 0", bus.instr_valid); end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_c3: got %b want 1", bus.instr_valid); end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            v = q_at(got_pc, i);
            checks++;
            if (v !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, v, 32'h100 + 32'(4 * i)); end
            v = q_at(got_ins, i);
            checks++;
            if (v !== ~(32'h100 + 32'(4 * i))) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", i, v, ~(32'h100 + 32'(4 * i))); end
        end
    endtask

    task automatic test_stall();
        int          held_err;
        logic [31:0] v;
        do_reset(1);
        dec_ready = 1'b0;
        held_err = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2 && (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100)) held_err++;
        end
        checks++;
        if (issued.size() != 2) begin failures++; $display("FAIL stall_req_count: got %0d want 2", issued.size()); end
        checks++;
        if (held_err != 0) begin failures++; $display("FAIL stall_head_held: got %0d unstable cycles want 0", held_err); end
        checks++;
        if (bus.instruction !== ~32'h100) begin failures++; $display("FAIL stall_head_data: got %h want %h", bus.instruction, ~32'h100); end
        dec_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (got_pc.size() < 6) begin failures++; $display("FAIL stall_resume_count: got %0d want >=6", got_pc.size()); end
        for (int i = 0; i < 6; i++) begin
            v = q_at(got_pc, i);
            checks++;
            if (v !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL stall_resume_pc[%0d]: got %h want %h", i, v, 32'h100 + 32'(4 * i)); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] v;
        do_reset(3);
        for (int i = 0; i < 10 && issued.size() < 2; i++) tick();
        checks++;
        if (issued.size() != 2) begin failures++; $display("FAIL flush_outstanding: got %0d want 2", issued.size()); end
        redir = 1'b1;
        redir_pc = 32'h2002;
        tick();
        redir = 1'b0;
        for (int i = 0; i < 30 && got_pc.size() < 2; i++) tick();
        v = q_at(issued, 2);
        checks++;
        if (v !== 32'h2000) begin failures++; $display("FAIL flush_next_req: got %h want 00002000", v); end
        v = q_at(got_pc, 0);
        checks++;
        if (v !== 32'h2000) begin failures++; $display("FAIL flush_first_pc: got %h want 00002000", v); end
        v = q_at(got_ins, 0);
        checks++;
        if (v !== ~32'h2000) begin failures++; $display("FAIL flush_first_data: got %h want %h", v, ~32'h2000); end
        v = q_at(got_pc, 1);
        checks++;
        if (v !== 32'h2004) begin failures++; $display("FAIL flush_second_pc: got %h want 00002004", v); end
    endtask

    task automatic test_redirect_pending();
        int          hold_err;
        logic [31:0] v;
        do_reset(1);
        mem_ready = 1'b0;
        redir = 1'b1;
        redir_pc = 32'h40;
        tick();
        redir = 1'b0;
        tick();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) begin
            failures++; $display("FAIL pend_req_before: got valid=%b addr=%h want valid=1 addr=00000040", bus.imem_req_valid, bus.imem_req_addr);
        end
        redir = 1'b1;
        redir_pc = 32'h80;
        tick();
        redir = 1'b0;
        hold_err = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) hold_err++;
            tick();
        end
        checks++;
        if (hold_err != 0) begin failures++; $display("FAIL pend_req_held: got %0d unstable cycles want 0", hold_err); end
        mem_ready = 1'b1;
        for (int i = 0; i < 30 && got_pc.size() < 1; i++) tick();
        v = q_at(issued, 0);
        checks++;
        if (v !== 32'h40) begin failures++; $display("FAIL pend_first_issue: got %h want 00000040", v); end
        v = q_at(issued, 1);
        checks++;
        if (v !== 32'h80) begin failures++; $display("FAIL pend_second_issue: got %h want 00000080", v); end
        v = q_at(got_pc, 0);
        checks++;
        if (v !== 32'h80) begin failures++; $display("FAIL pend_first_pc: got %h want 00000080", v); end
        v = q_at(got_ins, 0);
        checks++;
        if (v !== ~32'h80) begin failures++; $display("FAIL pend_first_data: got %h want %h", v, ~32'h80); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        do_reset(1);
        redir = 1'b1;
        redir_pc = 32'hFFFF_FFFB;
        tick();
        redir = 1'b0;
        for (int i = 0; i < 20 && got_pc.size() < 3; i++) tick();
        v = q_at(issued, 0);
        checks++;
        if (v !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_issue0: got %h want fffffff8", v); end
        v = q_at(issued, 1);
        checks++;
        if (v !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_issue1: got %h want fffffffc", v); end
        v = q_at(issued, 2);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL wrap_issue2: got %h want 00000000", v); end
        v = q_at(got_pc, 2);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL wrap_out_pc2: got %h want 00000000", v); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        do_reset(3);
        dec_ready = 1'b0;
        repeat (10) tick();
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        checks++;
        if (issued.size() != 3 || bus.instr_valid !== 1'b1) begin
            failures++; $display("FAIL mrst_setup: got issued=%0d valid=%b want issued=3 valid=1", issued.size(), bus.instr_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL mrst_instr_valid: got %b want 0", bus.instr_valid); end
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL mrst_req_valid: got %b want 0", bus.imem_req_valid); end
        mq.delete();
        issued.delete();
        got_pc.delete();
        got_ins.delete();
        rst = 1'b0;
        lat = 1;
        dec_ready = 1'b1;
        for (int i = 0; i < 20 && got_pc.size() < 1; i++) tick();
        v = q_at(got_pc, 0);
        checks++;
        if (v !== 32'h100) begin failures++; $display("FAIL mrst_restart_pc: got %h want 00000100", v); end
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_redirect_pending();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
